// File: rtl/hazard_controller.sv
// Hazard and pipeline-control unit for the 5-stage RV32 core: operand forwarding,
// load-use and mul/div interlocks, data-memory wait stalls and a stall-cycle counter.
module hazard_controller #(
    parameter int NUM_SRC    = 2,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [5*NUM_SRC-1:0]   ID_rs,
    input  logic [NUM_SRC-1:0]     ID_rs_used,
    input  logic [5*NUM_SRC-1:0]   EX_rs,
    input  logic [4:0]             EX_rd,
    input  logic [4:0]             MEM_rd,
    input  logic [4:0]             WB_rd,
    input  logic                   MEM_rf_we,
    input  logic                   WB_rf_we,
    input  logic                   EX_is_load,
    input  logic                   EX_is_md,
    input  logic                   EX_B,
    input  logic                   EX_J,
    input  logic                   alu_out_zero,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic [2*NUM_SRC-1:0]   fwd_sel,
    output logic                   IF_ID_stall,
    output logic                   IF_ID_flush,
    output logic                   ID_EX_stall,
    output logic                   ID_EX_flush,
    output logic                   EX_MEM_stall,
    output logic                   EX_MEM_flush,
    output logic                   MEM_WB_stall,
    output logic                   MEM_WB_flush,
    output logic                   md_start,
    output logic                   md_busy,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int MD_CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    md_state_t              state_r, state_nxt_s;
    logic [MD_CW-1:0]       cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0]       stall_cnt_r;
    logic [2*NUM_SRC-1:0]   fwd_sel_s;
    logic                   mem_stall_s, take_branch_s, md_stall_s, load_use_s, md_start_s;
    logic                   if_id_stall_s, if_id_flush_s, id_ex_stall_s, id_ex_flush_s;
    logic                   ex_mem_stall_s, ex_mem_flush_s, mem_wb_flush_s;

    assign mem_stall_s   = dmem_req & ~dmem_ready;
    assign take_branch_s = (EX_B & alu_out_zero) | EX_J;
    assign md_stall_s    = ((state_r == ST_IDLE) & EX_is_md) | (state_r == ST_BUSY);

    // Per-operand forwarding source; MEM is the younger producer and wins over WB
    always_comb begin
        fwd_sel_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (MEM_rf_we && (MEM_rd == EX_rs[5*i +: 5]) && (EX_rs[5*i +: 5] != 5'd0)) begin
                fwd_sel_s[2*i +: 2] = 2'b01;
            end else if (WB_rf_we && (WB_rd == EX_rs[5*i +: 5]) && (EX_rs[5*i +: 5] != 5'd0)) begin
                fwd_sel_s[2*i +: 2] = 2'b10;
            end else begin
                fwd_sel_s[2*i +: 2] = 2'b00;
            end
        end
    end

    // Load-use detection against every operand the ID instruction actually reads
    always_comb begin
        load_use_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (EX_is_load && (EX_rd != 5'd0) && ID_rs_used[i] && (ID_rs[5*i +: 5] == EX_rd)) begin
                load_use_s = 1'b1;
            end else begin
                load_use_s = load_use_s;
            end
        end
    end

    // Mul/div sequencing: start cycle plus MD_LATENCY-1 busy cycles, then a release cycle
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        md_start_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (EX_is_md && !take_branch_s) begin
                    md_start_s  = 1'b1;
                    cnt_nxt_s   = MD_LOAD;
                    state_nxt_s = (MD_LOAD == {MD_CW{1'b0}}) ? ST_DONE : ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r > MD_CW'(1)) begin
                    cnt_nxt_s = cnt_r - MD_CW'(1);
                end else begin
                    cnt_nxt_s   = {MD_CW{1'b0}};
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                // The finished instruction only leaves EX on an edge without a memory wait
                if (!mem_stall_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {MD_CW{1'b0}};
            end
        endcase
    end

    // Prioritised pipeline control; only the highest-priority hazard acts
    always_comb begin
        if_id_stall_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_stall_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_stall_s = 1'b0;
        ex_mem_flush_s = 1'b0;
        mem_wb_flush_s = 1'b0;
        if (mem_stall_s) begin
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
            mem_wb_flush_s = 1'b1;
        end else if (md_stall_s) begin
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
        end else if (take_branch_s) begin
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
        end else if (load_use_s) begin
            if_id_stall_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
        end else begin
            if_id_stall_s  = 1'b0;
        end
    end

    // Mul/div state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {MD_CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Saturating count of front-end stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (if_id_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign fwd_sel      = fwd_sel_s;
    assign IF_ID_stall  = if_id_stall_s;
    assign IF_ID_flush  = if_id_flush_s;
    assign ID_EX_stall  = id_ex_stall_s;
    assign ID_EX_flush  = id_ex_flush_s;
    assign EX_MEM_stall = ex_mem_stall_s;
    assign EX_MEM_flush = ex_mem_flush_s;
    assign MEM_WB_stall = 1'b0;
    assign MEM_WB_flush = mem_wb_flush_s;
    assign md_start     = md_start_s;
    assign md_busy      = (state_r != ST_IDLE);
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized
// traffic against a cycle-level reference model built from the pipeline rules.
module tb_hazard_controller;

    localparam int NS  = 2;
    localparam int LAT = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [5*NS-1:0] ID_rs, EX_rs;
    logic [NS-1:0]   ID_rs_used;
    logic [4:0]      EX_rd, MEM_rd, WB_rd;
    logic MEM_rf_we, WB_rf_we, EX_is_load, EX_is_md, EX_B, EX_J, alu_out_zero, dmem_req, dmem_ready;
    logic [2*NS-1:0] fwd_sel;
    logic IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
    logic EX_MEM_stall, EX_MEM_flush, MEM_WB_stall, MEM_WB_flush, md_start, md_busy;
    logic [CW-1:0]   stall_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit  m_active;
    int  m_left;
    int  m_cnt;
    logic [17:0] exp_v;
    bit  exp_ifs, exp_st, exp_ms;
    logic [17:0] obs_v;

    assign obs_v = {fwd_sel, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
                    EX_MEM_stall, EX_MEM_flush, MEM_WB_stall, MEM_WB_flush,
                    md_start, md_busy, stall_cnt};

    hazard_controller #(.NUM_SRC(NS), .MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rs_used(ID_rs_used), .EX_rs(EX_rs),
        .EX_rd(EX_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd), .MEM_rf_we(MEM_rf_we), .WB_rf_we(WB_rf_we),
        .EX_is_load(EX_is_load), .EX_is_md(EX_is_md), .EX_B(EX_B), .EX_J(EX_J),
        .alu_out_zero(alu_out_zero), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_sel(fwd_sel), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
        .EX_MEM_flush(EX_MEM_flush), .MEM_WB_stall(MEM_WB_stall), .MEM_WB_flush(MEM_WB_flush),
        .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic clear_inputs();
        ID_rs = '0; ID_rs_used = '0; EX_rs = '0; EX_rd = 5'd0; MEM_rd = 5'd0; WB_rd = 5'd0;
        MEM_rf_we = 1'b0; WB_rf_we = 1'b0; EX_is_load = 1'b0; EX_is_md = 1'b0;
        EX_B = 1'b0; EX_J = 1'b0; alu_out_zero = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Expected outputs for the current inputs from the hazard priority rules
    task automatic model_eval();
        logic [3:0] f;
        logic [7:0] sf;
        logic [4:0] rs;
        bit ms, tb, mds, lu, st;
        f = '0;
        for (int i = 0; i < NS; i++) begin
            rs = EX_rs[5*i +: 5];
            if (rs != 5'd0 && MEM_rf_we && MEM_rd == rs) f[2*i +: 2] = 2'b01;
            else if (rs != 5'd0 && WB_rf_we && WB_rd == rs) f[2*i +: 2] = 2'b10;
        end
        ms  = dmem_req && !dmem_ready;
        tb  = (EX_B && alu_out_zero) || EX_J;
        mds = m_active ? (m_left > 0) : EX_is_md;
        lu  = 1'b0;
        for (int i = 0; i < NS; i++)
            if (EX_is_load && EX_rd != 5'd0 && ID_rs_used[i] && ID_rs[5*i +: 5] == EX_rd) lu = 1'b1;
        // order: IF_ID s/f, ID_EX s/f, EX_MEM s/f, MEM_WB s/f
        if (ms)       sf = 8'b1010_1001;
        else if (mds) sf = 8'b1010_0100;
        else if (tb)  sf = 8'b0101_0000;
        else if (lu)  sf = 8'b1001_0000;
        else          sf = 8'b0000_0000;
        st = !m_active && EX_is_md && !tb;
        exp_v   = {f, sf, st, m_active, 4'(m_cnt)};
        exp_ifs = sf[7];
        exp_st  = st;
        exp_ms  = ms;
    endtask

    task automatic model_update();
        if (exp_ifs && m_cnt < 15) m_cnt++;
        if (!m_active) begin
            if (exp_st) begin m_active = 1'b1; m_left = LAT - 1; end
        end else if (m_left > 0) begin
            m_left--;
        end else if (!exp_ms) begin
            m_active = 1'b0;
        end
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_left = 0; m_cnt = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        checks++;
        if (obs_v !== 18'd0) begin errors++; $display("FAIL reset_outputs obs=%h exp=%h", obs_v, 18'd0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_forwarding();
        clear_inputs();
        MEM_rf_we = 1'b1; MEM_rd = 5'd5; WB_rf_we = 1'b1; WB_rd = 5'd5;
        EX_rs = {5'd5, 5'd5};
        #1; model_eval();
        checks++;
        if (fwd_sel !== 4'b0101) begin errors++; $display("FAIL fwd_mem_priority obs=%b exp=%b", fwd_sel, 4'b0101); end
        EX_rs = {5'd5, 5'd0}; MEM_rd = 5'd7;
        #1; model_eval();
        checks++;
        if (fwd_sel !== 4'b1000) begin errors++; $display("FAIL fwd_wb_and_x0 obs=%b exp=%b", fwd_sel, 4'b1000); end
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL fwd_vector obs=%h exp=%h", obs_v, exp_v); end
        step();
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        EX_is_load = 1'b1; EX_rd = 5'd3; ID_rs = {5'd3, 5'd4}; ID_rs_used = 2'b10;
        #1; model_eval();
        checks++;
        if ({IF_ID_stall, ID_EX_flush} !== 2'b11) begin
            errors++; $display("FAIL load_use_hit obs=%b exp=%b", {IF_ID_stall, ID_EX_flush}, 2'b11);
        end
        ID_rs_used = 2'b01;
        #1;
        checks++;
        if ({IF_ID_stall, ID_EX_flush} !== 2'b00) begin
            errors++; $display("FAIL load_use_unused obs=%b exp=%b", {IF_ID_stall, ID_EX_flush}, 2'b00);
        end
        EX_rd = 5'd0; ID_rs = {5'd0, 5'd0}; ID_rs_used = 2'b11;
        #1;
        checks++;
        if ({IF_ID_stall, ID_EX_flush} !== 2'b00) begin
            errors++; $display("FAIL load_use_x0 obs=%b exp=%b", {IF_ID_stall, ID_EX_flush}, 2'b00);
        end
        clear_inputs();
    endtask

    task automatic test_md_sequence();
        int nst, nstart;
        nst = 0; nstart = 0;
        apply_reset();
        EX_is_md = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1; model_eval();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL md_seq cycle %0d obs=%h exp=%h", c, obs_v, exp_v); end
            nst += int'(IF_ID_stall);
            nstart += int'(md_start);
            step();
        end
        EX_is_md = 1'b0;
        #1; model_eval();
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL md_busy_drop obs=%b exp=%b", md_busy, 1'b0); end
        checks++;
        if (nst != LAT) begin errors++; $display("FAIL md_stall_cycles obs=%0d exp=%0d", nst, LAT); end
        checks++;
        if (nstart != 1) begin errors++; $display("FAIL md_start_pulses obs=%0d exp=%0d", nstart, 1); end
        checks++;
        if (stall_cnt !== 4'd4) begin errors++; $display("FAIL md_stall_cnt obs=%0d exp=%0d", stall_cnt, 4); end
        step();
    endtask

    task automatic test_mem_stall_busy();
        apply_reset();
        for (int c = 1; c <= 8; c++) begin
            EX_is_md = (c <= 7);
            dmem_req = (c >= 3 && c <= 6);
            dmem_ready = 1'b0;
            #1; model_eval();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL memstall_seq cycle %0d obs=%h exp=%h", c, obs_v, exp_v); end
            if (c >= 3 && c <= 6) begin
                checks++;
                if ({IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_flush} !== 4'b1111) begin
                    errors++; $display("FAIL memstall_ctrl cycle %0d obs=%b exp=%b", c,
                        {IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_flush}, 4'b1111);
                end
            end
            if (c == 7) begin
                checks++;
                if ({md_busy, IF_ID_stall} !== 2'b10) begin
                    errors++; $display("FAIL md_release obs=%b exp=%b", {md_busy, IF_ID_stall}, 2'b10);
                end
            end
            if (c == 8) begin
                checks++;
                if (md_busy !== 1'b0) begin errors++; $display("FAIL md_idle_after obs=%b exp=%b", md_busy, 1'b0); end
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        apply_reset();
        EX_J = 1'b1; EX_is_load = 1'b1; EX_rd = 5'd3; ID_rs = {5'd3, 5'd0}; ID_rs_used = 2'b10;
        #1; model_eval();
        checks++;
        if ({IF_ID_flush, ID_EX_flush, IF_ID_stall} !== 3'b110) begin
            errors++; $display("FAIL jump_over_load_use obs=%b exp=%b", {IF_ID_flush, ID_EX_flush, IF_ID_stall}, 3'b110);
        end
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1; model_eval();
        checks++;
        if ({IF_ID_flush, ID_EX_flush} !== 2'b00) begin
            errors++; $display("FAIL jump_under_mem_stall obs=%b exp=%b", {IF_ID_flush, ID_EX_flush}, 2'b00);
        end
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL branch_vector obs=%h exp=%h", obs_v, exp_v); end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        EX_is_md = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({md_busy, stall_cnt} !== 5'd0) begin
            errors++; $display("FAIL async_reset_busy obs=%b exp=%b", {md_busy, stall_cnt}, 5'd0);
        end
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        apply_reset();
        EX_is_load = 1'b1; EX_rd = 5'd9; ID_rs = {5'd1, 5'd9}; ID_rs_used = 2'b01;
        for (int c = 0; c < 20; c++) begin
            #1; model_eval();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL sat_seq cycle %0d obs=%h exp=%h", c, obs_v, exp_v); end
            step();
        end
        #1;
        checks++;
        if (stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_cnt_saturate obs=%0d exp=%0d", stall_cnt, 15); end
        clear_inputs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                ID_rs[5*i +: 5] = 5'($urandom_range(0, 3));
                EX_rs[5*i +: 5] = 5'($urandom_range(0, 3));
            end
            ID_rs_used   = NS'($urandom_range(0, 3));
            EX_rd        = 5'($urandom_range(0, 3));
            MEM_rd       = 5'($urandom_range(0, 3));
            WB_rd        = 5'($urandom_range(0, 3));
            MEM_rf_we    = 1'($urandom_range(0, 1));
            WB_rf_we     = 1'($urandom_range(0, 1));
            EX_is_load   = 1'($urandom_range(0, 1));
            EX_is_md     = ($urandom_range(0, 5) == 0);
            EX_B         = 1'($urandom_range(0, 1));
            alu_out_zero = 1'($urandom_range(0, 1));
            EX_J         = ($urandom_range(0, 7) == 0);
            dmem_req     = 1'($urandom_range(0, 1));
            dmem_ready   = 1'($urandom_range(0, 1));
            #1; model_eval();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random cycle %0d obs=%h exp=%h", c, obs_v, exp_v); end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_load_use();
        test_md_sequence();
        test_mem_stall_busy();
        test_branch();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
